// File: rtl/riscv_arb_pkg.sv
// rtl/riscv_arb_pkg.sv - shared types and constants for the memory port arbiter
package riscv_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    localparam logic REQ_FETCH = 1'b0;
    localparam logic REQ_LSU   = 1'b1;

    localparam int WD_W = 8;

endpackage

// File: rtl/mux2x1.sv
// rtl/mux2x1.sv - two-input multiplexer, parameterised width
module mux2x1 #(
    parameter int WIDTH = 1
) (
    input  logic             sel_i,
    input  logic [WIDTH-1:0] d0_i,
    input  logic [WIDTH-1:0] d1_i,
    output logic [WIDTH-1:0] y_o
);

    assign y_o = sel_i ? d1_i : d0_i;

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin owner of the shared fetch/LSU memory port
module mem_port_arbiter
    import riscv_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0,
    input  logic                  req1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    input  logic                  we0,
    input  logic                  we1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  err,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  sel,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    input  logic                  mem_ready,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
    localparam logic [WD_W-1:0] WD_MAX  = {WD_W{1'b1}};

    arb_state_e      state_q, state_d;
    logic            sel_q, sel_d;
    logic            last_q, last_d;
    logic [WD_W-1:0] wd_q, wd_d;

    logic win;
    logic expired;
    logic done;
    logic other_req;

    // Tie goes to whoever was not served last.
    always_comb begin
        win = REQ_FETCH;
        if (req0 && req1)
            win = ~last_q;
        else if (req1)
            win = REQ_LSU;
    end

    assign expired   = (state_q == BUSY) && !mem_ready && (wd_q == WD_LAST);
    assign done      = (state_q == BUSY) && (mem_ready || (wd_q == WD_LAST));
    // The granted side still holds req this cycle, so only the other side counts.
    assign other_req = sel_q ? req0 : req1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= REQ_FETCH;
            last_q  <= REQ_LSU;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            wd_q    <= wd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        wd_d    = wd_q;
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    sel_d   = win;
                    state_d = BUSY;
                    wd_d    = '0;
                end
            end
            BUSY: begin
                if (done) begin
                    last_d = sel_q;
                    if (other_req) begin
                        sel_d = ~sel_q;
                        wd_d  = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (wd_q != WD_MAX) begin
                    wd_d = wd_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_req = (state_q == BUSY);
        gnt0    = done && (sel_q == REQ_FETCH);
        gnt1    = done && (sel_q == REQ_LSU);
        err     = expired;
    end

    assign sel   = sel_q;
    assign rdata = mem_rdata;

    mux2x1 #(.WIDTH(ADDR_WIDTH)) u_addr_mux (
        .sel_i (sel_q),
        .d0_i  (addr0),
        .d1_i  (addr1),
        .y_o   (mem_addr)
    );

    mux2x1 #(.WIDTH(DATA_WIDTH)) u_wdata_mux (
        .sel_i (sel_q),
        .d0_i  (wdata0),
        .d1_i  (wdata1),
        .y_o   (mem_wdata)
    );

    mux2x1 #(.WIDTH(1)) u_we_mux (
        .sel_i (sel_q),
        .d0_i  (we0),
        .d1_i  (we1),
        .y_o   (mem_we)
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        we0, we1;
    logic        gnt0, gnt1, err, sel, mem_req, mem_we;
    logic [31:0] rdata, mem_addr, mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(15)) dut (
        .clk       (clk),
        .rst       (rst),
        .req0      (req0),
        .req1      (req1),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .we0       (we0),
        .we1       (we1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .err       (err),
        .rdata     (rdata),
        .sel       (sel),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = 32'h0; addr1 = 32'h0; wdata0 = 0; wdata1 = 0;
        mem_ready = 0; mem_rdata = 0;
        tick(); tick();
        total++;
        if ({mem_req, gnt0, gnt1, err, sel} !== 5'b00000) begin
            bad++; $display("FAIL reset_outputs got={req,g0,g1,err,sel}=%b want=00000", {mem_req, gnt0, gnt1, err, sel});
        end
        rst = 1'b0;
        #1;
        total++;
        if (mem_req !== 1'b0) begin bad++; $display("FAIL reset_release_idle mem_req=%b want=0", mem_req); end
    endtask

    task automatic test_single_fetch();
        req0 = 1; addr0 = 32'h100; we0 = 0; addr1 = 32'h999;
        #1;
        total++;
        if (mem_req !== 1'b0) begin bad++; $display("FAIL fetch_idle_cycle mem_req=%b want=0", mem_req); end
        for (int c = 1; c <= 2; c++) begin
            tick();
            total++;
            if ({mem_req, sel, gnt0, gnt1} !== 4'b1000 || mem_addr !== 32'h100) begin
                bad++; $display("FAIL fetch_busy%0d req/sel/g0/g1=%b addr=%h want=1000 addr=00000100", c, {mem_req, sel, gnt0, gnt1}, mem_addr);
            end
        end
        tick();
        mem_ready = 1; mem_rdata = 32'hDEADBEEF;
        #1;
        total++;
        if ({gnt0, gnt1, err} !== 3'b100 || rdata !== 32'hDEADBEEF) begin
            bad++; $display("FAIL fetch_grant g0/g1/err=%b rdata=%h want=100 deadbeef", {gnt0, gnt1, err}, rdata);
        end
        tick();
        req0 = 0; mem_ready = 0;
        #1;
        total++;
        if ({mem_req, gnt0} !== 2'b00) begin bad++; $display("FAIL fetch_back_idle req/g0=%b want=00", {mem_req, gnt0}); end
    endtask

    task automatic test_tie();
        rst = 1; tick(); rst = 0;
        req0 = 1; req1 = 1; addr0 = 32'hA0; addr1 = 32'hB0; mem_ready = 1;
        #1;
        total++;
        if ({gnt0, gnt1, mem_req} !== 3'b000) begin bad++; $display("FAIL tie_idle_ignore_ready g0/g1/req=%b want=000", {gnt0, gnt1, mem_req}); end
        for (int c = 0; c < 4; c++) begin
            tick();
            total++;
            if (gnt0 !== (c % 2 == 0) || gnt1 !== (c % 2 == 1) || mem_addr !== ((c % 2 == 0) ? 32'hA0 : 32'hB0)) begin
                bad++; $display("FAIL tie_alt%0d g0=%b g1=%b addr=%h want g0=%0d g1=%0d", c, gnt0, gnt1, mem_addr, (c % 2 == 0), (c % 2 == 1));
            end
        end
        req0 = 0;
        tick();
        req1 = 0; mem_ready = 0;
        #1;
        total++;
        if (mem_req !== 1'b0) begin bad++; $display("FAIL tie_end_idle mem_req=%b want=0", mem_req); end
    endtask

    task automatic test_lsu_store();
        req1 = 1; we1 = 1; addr1 = 32'h2000; wdata1 = 32'h55;
        addr0 = 32'h44; wdata0 = 32'h77; we0 = 0;
        tick();
        total++;
        if ({mem_req, sel, mem_we, gnt1} !== 4'b1110 || mem_addr !== 32'h2000 || mem_wdata !== 32'h55) begin
            bad++; $display("FAIL store_busy req/sel/we/g1=%b addr=%h wdata=%h want=1110 2000 55", {mem_req, sel, mem_we, gnt1}, mem_addr, mem_wdata);
        end
        tick();
        mem_ready = 1;
        #1;
        total++;
        if ({gnt0, gnt1, err} !== 3'b010) begin bad++; $display("FAIL store_grant g0/g1/err=%b want=010", {gnt0, gnt1, err}); end
        tick();
        req1 = 0; we1 = 0; mem_ready = 0;
        #1;
        total++;
        if (mem_req !== 1'b0) begin bad++; $display("FAIL store_idle mem_req=%b want=0", mem_req); end
    endtask

    task automatic test_back_to_back();
        req0 = 1; addr0 = 32'h300; mem_ready = 1;
        #1;
        total++;
        if (mem_req !== 1'b0) begin bad++; $display("FAIL b2b_idle0 mem_req=%b want=0", mem_req); end
        tick();
        total++;
        if ({mem_req, gnt0, gnt1} !== 3'b110) begin bad++; $display("FAIL b2b_grant1 req/g0/g1=%b want=110", {mem_req, gnt0, gnt1}); end
        tick();
        total++;
        if ({mem_req, gnt0, gnt1} !== 3'b000) begin bad++; $display("FAIL b2b_gap req/g0/g1=%b want=000", {mem_req, gnt0, gnt1}); end
        tick();
        total++;
        if ({mem_req, gnt0, gnt1} !== 3'b110) begin bad++; $display("FAIL b2b_grant2 req/g0/g1=%b want=110", {mem_req, gnt0, gnt1}); end
        req0 = 0;
        tick();
        mem_ready = 0;
        #1;
        total++;
        if (mem_req !== 1'b0) begin bad++; $display("FAIL b2b_end mem_req=%b want=0", mem_req); end
    endtask

    task automatic test_timeout();
        req1 = 1; addr1 = 32'h4000; addr0 = 32'h500; mem_ready = 0;
        for (int c = 1; c <= 14; c++) begin
            tick();
            if (c == 3) req0 = 1;
            #1;
            total++;
            if ({mem_req, sel, gnt0, gnt1, err} !== 5'b11000) begin
                bad++; $display("FAIL timeout_wait%0d req/sel/g0/g1/err=%b want=11000", c, {mem_req, sel, gnt0, gnt1, err});
            end
        end
        tick();
        total++;
        if ({gnt0, gnt1, err} !== 3'b011) begin bad++; $display("FAIL timeout_abort g0/g1/err=%b want=011", {gnt0, gnt1, err}); end
        tick();
        req1 = 0;
        #1;
        total++;
        if ({mem_req, sel, gnt0, err} !== 4'b1000 || mem_addr !== 32'h500) begin
            bad++; $display("FAIL timeout_pending req/sel/g0/err=%b addr=%h want=1000 500", {mem_req, sel, gnt0, err}, mem_addr);
        end
        mem_ready = 1;
        #1;
        total++;
        if ({gnt0, gnt1, err} !== 3'b100) begin bad++; $display("FAIL timeout_pending_grant g0/g1/err=%b want=100", {gnt0, gnt1, err}); end
        req0 = 0;
        tick();
        mem_ready = 0;
        #1;
        total++;
        if (mem_req !== 1'b0) begin bad++; $display("FAIL timeout_end mem_req=%b want=0", mem_req); end
    endtask

    task automatic test_reset_mid();
        req1 = 1; addr1 = 32'h6000;
        tick();
        tick();
        total++;
        if ({mem_req, sel} !== 2'b11) begin bad++; $display("FAIL rstmid_busy req/sel=%b want=11", {mem_req, sel}); end
        rst = 1;
        #1;
        total++;
        if ({mem_req, sel, gnt0, gnt1} !== 4'b0000) begin bad++; $display("FAIL rstmid_async req/sel/g0/g1=%b want=0000", {mem_req, sel, gnt0, gnt1}); end
        tick();
        rst = 0; req0 = 1; req1 = 1; addr0 = 32'h700;
        #1;
        total++;
        if (mem_req !== 1'b0) begin bad++; $display("FAIL rstmid_idle mem_req=%b want=0", mem_req); end
        tick();
        total++;
        if ({mem_req, sel} !== 2'b10 || mem_addr !== 32'h700) begin
            bad++; $display("FAIL rstmid_tie req/sel=%b addr=%h want=10 700", {mem_req, sel}, mem_addr);
        end
        mem_ready = 1;
        #1;
        total++;
        if ({gnt0, gnt1} !== 2'b10) begin bad++; $display("FAIL rstmid_grant g0/g1=%b want=10", {gnt0, gnt1}); end
        req0 = 0; req1 = 0;
        tick();
        mem_ready = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL sim_timeout bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single_fetch();
        test_tie();
        test_lsu_store();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
